// File: rtl/pc_gen_bp_pkg.sv
// Shared definitions for the fetch-address generator and its BTB.
// Counter encodings, width defaults and the 2-bit counter step.
package pc_gen_bp_pkg;

  localparam int AddrLen = 32;
  localparam logic [AddrLen-1:0] ZERO_WORD = '0;
  localparam logic Enable = 1'b1;
  localparam logic Disable = 1'b0;
  localparam int INST_BYTES_DEF = 4;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  function automatic ctr_e ctr_step(
    input ctr_e c,
    input logic taken
  );
    logic [1:0] v;
    v = c;
    unique case (1'b1)
      (taken && c != CTR_ST):   v = v + 2'd1;
      (!taken && c != CTR_SNT): v = v - 2'd1;
      default:                  v = c;
    endcase
    return ctr_e'(v);
  endfunction

endpackage

// File: rtl/pc_gen_bp_if.sv
// EX/IF-facing bundle of the fetch-address generator.
// master drives redirect/update/handshake; slave is the generator.
interface pc_gen_bp_if #(
  parameter int ADDR_W = 32
);

  logic              stall_i;
  logic              fetch_ready_i;
  logic              redirect_valid_i;
  logic [ADDR_W-1:0] redirect_pc_i;
  logic              upd_valid_i;
  logic [ADDR_W-1:0] upd_pc_i;
  logic              upd_taken_i;
  logic [ADDR_W-1:0] upd_target_i;
  logic [ADDR_W-1:0] pc_o;
  logic              pc_valid_o;
  logic              pc_redirect_o;
  logic              pred_taken_o;
  logic [ADDR_W-1:0] pred_target_o;

  modport master (
    output stall_i, fetch_ready_i,
    output redirect_valid_i, redirect_pc_i,
    output upd_valid_i, upd_pc_i,
    output upd_taken_i, upd_target_i,
    input  pc_o, pc_valid_o, pc_redirect_o,
    input  pred_taken_o, pred_target_o
  );

  modport slave (
    input  stall_i, fetch_ready_i,
    input  redirect_valid_i, redirect_pc_i,
    input  upd_valid_i, upd_pc_i,
    input  upd_taken_i, upd_target_i,
    output pc_o, pc_valid_o, pc_redirect_o,
    output pred_taken_o, pred_target_o
  );

endinterface

// File: rtl/pc_gen_bp_btb_dm.sv
// Direct-mapped BTB with 2-bit counters; word addresses in.
// Read is combinational, so a same-cycle write is seen next cycle.
module btb_dm
  import pc_gen_bp_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int ENTRIES = 16,
  localparam int IDX_W  = $clog2(ENTRIES),
  localparam int WA_W   = ADDR_W - 2,
  localparam int TAG_W  = WA_W - IDX_W
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic [WA_W-1:0]   i_rd_wa,
  output logic              o_taken,
  output logic [ADDR_W-1:0] o_target,
  input  logic              i_upd_valid,
  input  logic [WA_W-1:0]   i_upd_wa,
  input  logic              i_upd_taken,
  input  logic [ADDR_W-1:0] i_upd_target
);

  logic              r_valid  [ENTRIES];
  ctr_e              r_ctr    [ENTRIES];
  logic [TAG_W-1:0]  r_tag    [ENTRIES];
  logic [ADDR_W-1:0] r_target [ENTRIES];

  logic [IDX_W-1:0] w_rd_idx;
  logic [TAG_W-1:0] w_rd_tag;
  logic [IDX_W-1:0] w_up_idx;
  logic [TAG_W-1:0] w_up_tag;
  logic             w_rd_hit;
  logic             w_up_hit;
  logic             w_we;

  assign w_rd_idx = i_rd_wa[IDX_W-1:0];
  assign w_rd_tag = i_rd_wa[WA_W-1:IDX_W];
  assign w_up_idx = i_upd_wa[IDX_W-1:0];
  assign w_up_tag = i_upd_wa[WA_W-1:IDX_W];

  assign w_rd_hit = r_valid[w_rd_idx] &&
                    (r_tag[w_rd_idx] == w_rd_tag);
  assign w_up_hit = r_valid[w_up_idx] &&
                    (r_tag[w_up_idx] == w_up_tag);

  assign o_taken  = w_rd_hit && r_ctr[w_rd_idx][1];
  assign o_target = r_target[w_rd_idx];

  assign w_we = i_en && i_upd_valid;

  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= Disable;
        r_ctr[i]   <= CTR_WNT;
      end
    end else if (w_we) begin
      if (w_up_hit) begin
        r_ctr[w_up_idx] <= ctr_step(r_ctr[w_up_idx], i_upd_taken);
      end else if (i_upd_taken) begin
        r_valid[w_up_idx] <= Enable;
        r_ctr[w_up_idx]   <= CTR_WT;
      end
    end
  end

  // Tag/target need no reset: they are qualified by r_valid.
  always_ff @(posedge clk) begin
    if (i_rst_n && w_we && i_upd_taken) begin
      r_tag[w_up_idx]    <= w_up_tag;
      r_target[w_up_idx] <= i_upd_target;
    end
  end

endmodule

// File: rtl/pc_gen_bp.sv
// Fetch PC register with redirect priority and BTB prediction.
// Redirect beats stall; predicted/sequential advance needs IF accept.
module pc_gen_bp
  import pc_gen_bp_pkg::*;
#(
  parameter int              ADDR_W     = AddrLen,
  parameter int              ENTRIES    = 16,
  parameter int              INST_BYTES = INST_BYTES_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic         clk,
  input logic         rst,
  input logic         rdy,
  pc_gen_bp_if.slave  bus
);

  logic [ADDR_W-1:0] r_pc;
  logic              r_valid;
  logic              r_redir;

  logic              w_pred_taken;
  logic [ADDR_W-1:0] w_pred_target;
  logic [ADDR_W-1:0] w_seq_pc;
  logic [ADDR_W-1:0] w_next_pc;
  logic              w_advance;

  btb_dm #(
    .ADDR_W  (ADDR_W),
    .ENTRIES (ENTRIES)
  ) u_btb (
    .clk          (clk),
    .i_rst_n      (rst),
    .i_en         (rdy),
    .i_rd_wa      (r_pc[ADDR_W-1:2]),
    .o_taken      (w_pred_taken),
    .o_target     (w_pred_target),
    .i_upd_valid  (bus.upd_valid_i),
    .i_upd_wa     (bus.upd_pc_i[ADDR_W-1:2]),
    .i_upd_taken  (bus.upd_taken_i),
    .i_upd_target (bus.upd_target_i)
  );

  assign w_seq_pc  = r_pc + ADDR_W'(INST_BYTES);
  assign w_next_pc = w_pred_taken ? w_pred_target : w_seq_pc;
  assign w_advance = bus.fetch_ready_i && !bus.stall_i;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc    <= RESET_PC;
      r_valid <= Disable;
      r_redir <= Disable;
    end else if (rdy) begin
      r_valid <= Enable;
      if (bus.redirect_valid_i) begin
        r_pc    <= bus.redirect_pc_i;
        r_redir <= Enable;
      end else begin
        r_redir <= Disable;
        if (w_advance) begin
          r_pc <= w_next_pc;
        end
      end
    end
  end

  assign bus.pc_o          = r_pc;
  assign bus.pc_valid_o    = r_valid;
  assign bus.pc_redirect_o = r_redir;
  assign bus.pred_taken_o  = w_pred_taken;
  assign bus.pred_target_o = w_pred_target;

endmodule

// File: tb/tb_pc_gen_bp.sv
// Directed bench for pc_gen_bp: sequencing, redirect, BTB training.
// Each scenario task drives stimulus and checks inline.
module tb_pc_gen_bp;

  logic clk;
  logic rst;
  logic rdy;
  int   errors;
  int   checks;

  pc_gen_bp_if #(.ADDR_W(32)) bus ();

  pc_gen_bp dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.stall_i          = 1'b0;
    bus.fetch_ready_i    = 1'b0;
    bus.redirect_valid_i = 1'b0;
    bus.redirect_pc_i    = '0;
    bus.upd_valid_i      = 1'b0;
    bus.upd_pc_i         = '0;
    bus.upd_taken_i      = 1'b0;
    bus.upd_target_i     = '0;
  endtask

  task automatic redir(input logic [31:0] a);
    bus.redirect_valid_i = 1'b1;
    bus.redirect_pc_i    = a;
    step();
    bus.redirect_valid_i = 1'b0;
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk,
                     input logic [31:0] tg);
    bus.upd_valid_i  = 1'b1;
    bus.upd_pc_i     = pc;
    bus.upd_taken_i  = tk;
    bus.upd_target_i = tg;
    step();
    bus.upd_valid_i  = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b0;
    rdy = 1'b1;
    step();
    step();
    checks++;
    if (bus.pc_o !== 32'h0) begin
      errors++; $display("FAIL reset_pc got=%h exp=%h", bus.pc_o, 32'h0);
    end
    checks++;
    if (bus.pc_valid_o !== 1'b0) begin
      errors++; $display("FAIL reset_valid got=%b exp=0", bus.pc_valid_o);
    end
    checks++;
    if (bus.pc_redirect_o !== 1'b0) begin
      errors++; $display("FAIL reset_redir got=%b exp=0", bus.pc_redirect_o);
    end
    checks++;
    if (bus.pred_taken_o !== 1'b0) begin
      errors++; $display("FAIL reset_pred got=%b exp=0", bus.pred_taken_o);
    end
  endtask

  task automatic test_sequential();
    rst = 1'b1;
    step();
    checks++;
    if (bus.pc_valid_o !== 1'b1 || bus.pc_o !== 32'h0) begin
      errors++;
      $display("FAIL seq_start got valid=%b pc=%h exp valid=1 pc=0",
               bus.pc_valid_o, bus.pc_o);
    end
    bus.fetch_ready_i = 1'b1;
    step();
    checks++;
    if (bus.pc_o !== 32'h4) begin
      errors++; $display("FAIL seq_pc4 got=%h exp=%h", bus.pc_o, 32'h4);
    end
    step();
    checks++;
    if (bus.pc_o !== 32'h8 || bus.pred_taken_o !== 1'b0) begin
      errors++;
      $display("FAIL seq_pc8 got pc=%h pred=%b exp pc=8 pred=0",
               bus.pc_o, bus.pred_taken_o);
    end
  endtask

  task automatic test_redirect_stall();
    bus.stall_i = 1'b1;
    redir(32'h100);
    checks++;
    if (bus.pc_o !== 32'h100 || bus.pc_redirect_o !== 1'b1) begin
      errors++;
      $display("FAIL redir_load got pc=%h pulse=%b exp pc=100 pulse=1",
               bus.pc_o, bus.pc_redirect_o);
    end
    step();
    checks++;
    if (bus.pc_o !== 32'h100 || bus.pc_redirect_o !== 1'b0) begin
      errors++;
      $display("FAIL redir_pulse got pc=%h pulse=%b exp pc=100 pulse=0",
               bus.pc_o, bus.pc_redirect_o);
    end
    step();
    checks++;
    if (bus.pc_o !== 32'h100) begin
      errors++; $display("FAIL stall_hold got=%h exp=%h", bus.pc_o, 32'h100);
    end
    idle();
  endtask

  task automatic test_predict();
    upd(32'h10, 1'b1, 32'h40);
    redir(32'h10);
    checks++;
    if (bus.pred_taken_o !== 1'b1 || bus.pred_target_o !== 32'h40) begin
      errors++;
      $display("FAIL pred_hit got tk=%b tg=%h exp tk=1 tg=40",
               bus.pred_taken_o, bus.pred_target_o);
    end
    bus.fetch_ready_i = 1'b1;
    step();
    bus.fetch_ready_i = 1'b0;
    checks++;
    if (bus.pc_o !== 32'h40 || bus.pred_taken_o !== 1'b0) begin
      errors++;
      $display("FAIL pred_jump got pc=%h tk=%b exp pc=40 tk=0",
               bus.pc_o, bus.pred_taken_o);
    end
  endtask

  task automatic test_counter();
    redir(32'h10);
    // Not-taken update on the looked-up entry: lookup still sees ctr=10.
    bus.upd_valid_i   = 1'b1;
    bus.upd_pc_i      = 32'h10;
    bus.upd_taken_i   = 1'b0;
    bus.fetch_ready_i = 1'b1;
    step();
    bus.upd_valid_i   = 1'b0;
    bus.fetch_ready_i = 1'b0;
    checks++;
    if (bus.pc_o !== 32'h40) begin
      errors++; $display("FAIL collide_pc got=%h exp=%h", bus.pc_o, 32'h40);
    end
    upd(32'h10, 1'b0, 32'h0);
    redir(32'h10);
    checks++;
    if (bus.pred_taken_o !== 1'b0) begin
      errors++; $display("FAIL ctr_nt got=%b exp=0", bus.pred_taken_o);
    end
    bus.fetch_ready_i = 1'b1;
    step();
    bus.fetch_ready_i = 1'b0;
    checks++;
    if (bus.pc_o !== 32'h14) begin
      errors++; $display("FAIL ctr_seq got=%h exp=%h", bus.pc_o, 32'h14);
    end
    upd(32'h10, 1'b0, 32'h0);
    upd(32'h10, 1'b0, 32'h0);
    upd(32'h10, 1'b1, 32'h60);
    redir(32'h10);
    checks++;
    if (bus.pred_taken_o !== 1'b0) begin
      errors++; $display("FAIL ctr_sat_lo got=%b exp=0", bus.pred_taken_o);
    end
    upd(32'h10, 1'b1, 32'h60);
    checks++;
    if (bus.pred_taken_o !== 1'b1 || bus.pred_target_o !== 32'h60) begin
      errors++;
      $display("FAIL ctr_retrain got tk=%b tg=%h exp tk=1 tg=60",
               bus.pred_taken_o, bus.pred_target_o);
    end
  endtask

  task automatic test_replace();
    upd(32'h50, 1'b1, 32'h80);
    redir(32'h10);
    checks++;
    if (bus.pred_taken_o !== 1'b0) begin
      errors++; $display("FAIL repl_old got=%b exp=0", bus.pred_taken_o);
    end
    bus.fetch_ready_i = 1'b1;
    step();
    bus.fetch_ready_i = 1'b0;
    checks++;
    if (bus.pc_o !== 32'h14) begin
      errors++; $display("FAIL repl_seq got=%h exp=%h", bus.pc_o, 32'h14);
    end
    redir(32'h50);
    checks++;
    if (bus.pred_taken_o !== 1'b1 || bus.pred_target_o !== 32'h80) begin
      errors++;
      $display("FAIL repl_new got tk=%b tg=%h exp tk=1 tg=80",
               bus.pred_taken_o, bus.pred_target_o);
    end
    bus.fetch_ready_i = 1'b1;
    step();
    bus.fetch_ready_i = 1'b0;
    checks++;
    if (bus.pc_o !== 32'h80) begin
      errors++; $display("FAIL repl_jump got=%h exp=%h", bus.pc_o, 32'h80);
    end
  endtask

  task automatic test_wrap();
    redir(32'hFFFF_FFFC);
    checks++;
    if (bus.pred_taken_o !== 1'b0) begin
      errors++; $display("FAIL wrap_pred got=%b exp=0", bus.pred_taken_o);
    end
    bus.fetch_ready_i = 1'b1;
    step();
    bus.fetch_ready_i = 1'b0;
    checks++;
    if (bus.pc_o !== 32'h0) begin
      errors++; $display("FAIL wrap_pc got=%h exp=%h", bus.pc_o, 32'h0);
    end
  endtask

  task automatic test_freeze();
    redir(32'h50);
    rdy                  = 1'b0;
    bus.redirect_valid_i = 1'b1;
    bus.redirect_pc_i    = 32'h200;
    bus.upd_valid_i      = 1'b1;
    bus.upd_pc_i         = 32'h50;
    bus.upd_taken_i      = 1'b0;
    bus.fetch_ready_i    = 1'b1;
    step();
    step();
    step();
    checks++;
    if (bus.pc_o !== 32'h50 || bus.pc_redirect_o !== 1'b1) begin
      errors++;
      $display("FAIL frz_pc got pc=%h pulse=%b exp pc=50 pulse=1",
               bus.pc_o, bus.pc_redirect_o);
    end
    checks++;
    if (bus.pred_taken_o !== 1'b1) begin
      errors++; $display("FAIL frz_btb got=%b exp=1", bus.pred_taken_o);
    end
    rdy = 1'b1;
    idle();
    step();
    checks++;
    if (bus.pc_o !== 32'h50 || bus.pc_redirect_o !== 1'b0 ||
        bus.pred_taken_o !== 1'b1) begin
      errors++;
      $display("FAIL frz_resume got pc=%h pulse=%b tk=%b exp 50/0/1",
               bus.pc_o, bus.pc_redirect_o, bus.pred_taken_o);
    end
  endtask

  task automatic test_reset_mid();
    bus.redirect_valid_i = 1'b1;
    bus.redirect_pc_i    = 32'h300;
    bus.upd_valid_i      = 1'b1;
    bus.upd_pc_i         = 32'h300;
    bus.upd_taken_i      = 1'b1;
    bus.upd_target_i     = 32'h500;
    bus.fetch_ready_i    = 1'b1;
    rst = 1'b0;
    step();
    checks++;
    if (bus.pc_o !== 32'h0 || bus.pc_valid_o !== 1'b0 ||
        bus.pc_redirect_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst got pc=%h v=%b pulse=%b exp 0/0/0",
               bus.pc_o, bus.pc_valid_o, bus.pc_redirect_o);
    end
    rst = 1'b1;
    idle();
    redir(32'h50);
    checks++;
    if (bus.pred_taken_o !== 1'b0 || bus.pc_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL mid_clr got tk=%b v=%b exp tk=0 v=1",
               bus.pred_taken_o, bus.pc_valid_o);
    end
    redir(32'h300);
    checks++;
    if (bus.pred_taken_o !== 1'b0) begin
      errors++; $display("FAIL mid_upd got=%b exp=0", bus.pred_taken_o);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b0;
    rdy    = 1'b0;
    idle();
    test_reset();
    test_sequential();
    test_redirect_stall();
    test_predict();
    test_counter();
    test_replace();
    test_wrap();
    test_freeze();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
